uart_tx_ctrl: RTL

Memory-mapped UART transmit controller on the CPU IO bus. It replaces the simulation-only print stub with a real serial path. CPU byte writes to the UART IO window are queued in a TX FIFO. A frame FSM with a baud divider drains the queue onto the serial line as 8N1 frames, and a status word is readable by the CPU for flow control.

---
 rtl/uart_tx_ctrl.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_ctrl
// Description : Memory-mapped UART transmitter. CPU byte writes to the UART
//               IO window are queued in a TX FIFO and sent as 8N1 frames.
//               A status word is readable for flow control.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl #(
    parameter int IO_CTRL_BIT   = 22,
    parameter int UART_CTRL_BIT = 4,
    parameter int CLKS_PER_BIT  = 868,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] mem_addr_i,
    input  logic        mem_rstrb_i,
    output logic [31:0] mem_rdata_o,
    input  logic [3:0]  mem_wmask_i,
    input  logic [31:0] mem_wdata_i,
    output logic        tx_o
);

    localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w  = c_ptr_w + 1;
    localparam int c_baud_w = $clog2(CLKS_PER_BIT);

    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [c_baud_w-1:0] c_baud_one  = c_baud_w'(1);
    localparam logic [c_baud_w-1:0] c_baud_zero = '0;
    localparam logic [c_cnt_w-1:0]  c_depth     = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0]  c_ptr_one   = c_ptr_w'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [c_baud_w-1:0]   r_baud;
    logic [2:0]            r_bit_idx;
    logic [7:0]            r_shift;
    logic                  r_tx;
    logic [7:0]            r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;
    logic                  r_overflow;
    logic [31:0]           r_rdata;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t                w_state_next;
    logic [c_baud_w-1:0]   w_baud_next;
    logic [2:0]            w_bit_idx_next;
    logic [7:0]            w_shift_next;
    logic                  w_tx_next;
    logic                  w_pop;
    logic                  w_sel;
    logic                  w_push_req;
    logic                  w_push;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_busy;
    logic                  w_baud_end;
    logic                  w_read;
    logic [7:0]            w_head;
    logic [7:0]            w_count8;
    logic [31:0]           w_status;
    logic                  w_unused;

    assign w_sel      = mem_addr_i[IO_CTRL_BIT] & mem_addr_i[UART_CTRL_BIT];
    assign w_push_req = w_sel & mem_wmask_i[0];
    assign w_read     = w_sel & mem_rstrb_i;
    // Fullness is judged before any same-cycle pop, so a push into a full
    // FIFO is dropped even if a byte leaves on the same edge.
    assign w_full     = (r_count == c_depth);
    assign w_empty    = (r_count == '0);
    assign w_push     = w_push_req & ~w_full;
    assign w_busy     = (r_state != S_IDLE);
    assign w_baud_end = (r_baud == c_baud_last);
    assign w_head     = r_mem[r_rd_ptr];

    // Address/data bits outside the decode and the low data byte are don't-care.
    assign w_unused = &{1'b0, mem_addr_i, mem_wdata_i[31:8], mem_wmask_i[3:1]};

    generate
        if (c_cnt_w >= 8) begin : g_cnt_trunc
            assign w_count8 = r_count[7:0];
        end else begin : g_cnt_ext
            assign w_count8 = {{(8 - c_cnt_w){1'b0}}, r_count};
        end
    endgenerate

    assign w_status = {16'h0000, w_count8, 4'h0, r_overflow, w_busy, w_empty, w_full};

    assign tx_o        = r_tx;
    assign mem_rdata_o = r_rdata;

    // FIFO storage: written on every accepted push, no reset needed
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= mem_wdata_i[7:0];
        end
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow flag and registered status read; a drop beats a clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_overflow <= 1'b0;
            r_rdata    <= '0;
        end else begin
            if (w_read) begin
                r_rdata <= w_status;
            end
            if (w_push_req && w_full) begin
                r_overflow <= 1'b1;
            end else if (w_read) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Frame FSM state and datapath registers; tx_o lags the state by one cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
        end
    end

    // Frame FSM next-state, pop request and serial line value
    always_comb begin
        w_state_next   = r_state;
        w_baud_next    = r_baud;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_tx_next      = 1'b1;
        w_pop          = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_next = 1'b1;
                if (!w_empty) begin
                    w_pop          = 1'b1;
                    w_shift_next   = w_head;
                    w_baud_next    = c_baud_zero;
                    w_bit_idx_next = 3'd0;
                    w_state_next   = S_START;
                end
            end
            S_START: begin
                w_tx_next = 1'b0;
                if (w_baud_end) begin
                    w_baud_next  = c_baud_zero;
                    w_state_next = S_DATA;
                end else begin
                    w_baud_next = r_baud + c_baud_one;
                end
            end
            S_DATA: begin
                w_tx_next = r_shift[0];
                if (w_baud_end) begin
                    w_baud_next    = c_baud_zero;
                    w_shift_next   = {1'b0, r_shift[7:1]};
                    w_bit_idx_next = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                    end
                end else begin
                    w_baud_next = r_baud + c_baud_one;
                end
            end
            S_STOP: begin
                w_tx_next = 1'b1;
                if (w_baud_end) begin
                    w_baud_next = c_baud_zero;
                    if (!w_empty) begin
                        // Chain straight into the next frame with no idle gap
                        w_pop          = 1'b1;
                        w_shift_next   = w_head;
                        w_bit_idx_next = 3'd0;
                        w_state_next   = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_baud_next = r_baud + c_baud_one;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

`ifndef SYNTHESIS
    // Echo each accepted byte to the simulation log
    always @(posedge clk_i) begin
        if (!rst_i && w_push) begin
            $display("[UART]: %c", mem_wdata_i[7:0]);
        end
    end
`endif

endmodule
`default_nettype wire
